// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment bus decoder and display-driver checks.
// Patterns are seg[6:0] active low, ordered g..a.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIG_NONE  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Exactly one digit select driven low.
    function automatic logic one_low(input logic [3:0] d);
        return (d == 4'hE) || (d == 4'hD) || (d == 4'hB) || (d == 4'h7);
    endfunction

    // Two or more digit selects driven low at once.
    function automatic logic multi_low(input logic [3:0] d);
        return $countones(~d) >= 2;
    endfunction

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Maps an active-low 7-segment pattern to a BCD value with blank/illegal flags.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input pattern.
module seg_pattern_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       is_blank,
    output logic       is_err
);

    always_comb begin
        value    = 4'hF;
        is_blank = 1'b0;
        is_err   = 1'b0;
        case (seg)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_bus_decoder.sv
// Reconstructs four BCD digits plus decimal points from a multiplexed active-low seg/dig bus.
// Latency: a stable input first sampled at edge 1 is captured at edge SETTLE+1.
// Backpressure: none; passive observer of the display bus.
module seven_seg_bus_decoder
    import seven_seg_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  dig_in,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  digit_valid,
    output logic [3:0]  blank,
    output logic [3:0]  code_err,
    output logic        sel_err,
    output logic        frame_done
);

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    logic [7:0] seg_s;
    logic [3:0] dig_s;
    logic [7:0] cnt;
    logic [3:0] seen;
    state_t     state;

    logic       same;
    logic       capture;
    logic [3:0] seen_set;
    logic [3:0] dec_val;
    logic       dec_blank;
    logic       dec_err;

    seg_pattern_to_bcd u_dec (
        .seg      (seg_s[6:0]),
        .value    (dec_val),
        .is_blank (dec_blank),
        .is_err   (dec_err)
    );

    assign same     = (seg_in == seg_s) && (dig_in == dig_s);
    // The edge where cnt would step to SETTLE is the capture edge.
    assign capture  = same && (state == ST_WAIT) && (cnt == SETTLE_M1);
    // In WAIT the sampled select is one-hot-low, so its inverse is the seen mask.
    assign seen_set = seen | ~dig_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s       <= 8'hFF;
            dig_s       <= DIG_NONE;
            cnt         <= 8'd0;
            state       <= ST_IDLE;
            seen        <= 4'd0;
            digits      <= 16'hFFFF;
            dp          <= 4'd0;
            digit_valid <= 4'd0;
            blank       <= 4'd0;
            code_err    <= 4'd0;
            sel_err     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!same) begin
                seg_s <= seg_in;
                dig_s <= dig_in;
                cnt   <= 8'd0;
                state <= one_low(dig_in) ? ST_WAIT : ST_IDLE;
                if (multi_low(dig_in))
                    sel_err <= 1'b1;
            end else begin
                if (cnt != SETTLE_C)
                    cnt <= cnt + 8'd1;
                if (capture) begin
                    state <= ST_HOLD;
                    for (int d = 0; d < 4; d++) begin
                        if (!dig_s[d]) begin
                            digits[4*d +: 4] <= dec_val;
                            dp[d]            <= ~seg_s[7];
                            digit_valid[d]   <= 1'b1;
                            blank[d]         <= dec_blank;
                            code_err[d]      <= dec_err;
                        end
                    end
                    if (seen_set == 4'hF) begin
                        seen       <= 4'd0;
                        frame_done <= 1'b1;
                    end else begin
                        seen <= seen_set;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_bus_decoder.sv
// Directed bench for seven_seg_bus_decoder with SETTLE=4.
module tb_seven_seg_bus_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_in;
    logic [3:0]  dig_in;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_valid;
    logic [3:0]  blank;
    logic [3:0]  code_err;
    logic        sel_err;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int fcount = 0;

    logic [7:0] scan_seg [0:3];

    seven_seg_bus_decoder #(.SETTLE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_in      (dig_in),
        .digits      (digits),
        .dp          (dp),
        .digit_valid (digit_valid),
        .blank       (blank),
        .code_err    (code_err),
        .sel_err     (sel_err),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_done === 1'b1)
            fcount++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        scan_seg[0] = 8'hF9;
        scan_seg[1] = 8'hA4;
        scan_seg[2] = 8'h30;
        scan_seg[3] = 8'h99;

        rst_n  = 1'b0;
        seg_in = 8'hFF;
        dig_in = 4'hF;
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("rst_digits", digits, 16'hFFFF);
        chk("rst_dp", 16'(dp), 16'h0);
        chk("rst_valid", 16'(digit_valid), 16'h0);
        chk("rst_blank", 16'(blank), 16'h0);
        chk("rst_code_err", 16'(code_err), 16'h0);
        chk("rst_sel_err", 16'(sel_err), 16'h0);
        chk("rst_no_frame", 16'(fcount), 16'd0);

        // Single digit 2 with dp lit, held for 10 cycles.
        dig_in = 4'hE;
        seg_in = 8'h24;
        step(4);
        chk("hold_edge4_valid", 16'(digit_valid), 16'h0);
        step(1);
        chk("hold_edge5_valid", 16'(digit_valid), 16'h1);
        chk("hold_edge5_digit", 16'(digits[3:0]), 16'h2);
        chk("hold_edge5_dp", 16'(dp), 16'h1);
        step(5);
        chk("hold_end_digits", digits, 16'hFFF2);
        chk("hold_no_frame", 16'(fcount), 16'd0);

        // Two full scans of 1,2,3,4 with dp on digit 2.
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                dig_in = 4'(~(4'b0001 << d));
                seg_in = scan_seg[d];
                if (d == 3) begin
                    step(5);
                    chk("scan_frame_pulse", 16'(frame_done), 16'h1);
                    chk("scan_digits", digits, 16'h4321);
                    step(1);
                    chk("scan_frame_drop", 16'(frame_done), 16'h0);
                    step(2);
                end else begin
                    step(8);
                end
            end
        end
        chk("scan_dp", 16'(dp), 16'h4);
        chk("scan_valid", 16'(digit_valid), 16'hF);
        chk("scan_frame_count", 16'(fcount), 16'd2);

        // Dwell of 3 cycles is too short to capture.
        dig_in = 4'hD;
        seg_in = 8'h92;
        step(3);
        dig_in = 4'hF;
        seg_in = 8'hFF;
        step(6);
        chk("glitch_digits", digits, 16'h4321);

        // Illegal pattern on digit 1, blank on digit 2.
        dig_in = 4'hD;
        seg_in = 8'hD5;
        step(8);
        chk("illegal_code_err", 16'(code_err), 16'h2);
        chk("illegal_digit", 16'(digits[7:4]), 16'hF);
        chk("illegal_blank", 16'(blank), 16'h0);
        dig_in = 4'hB;
        seg_in = 8'hFF;
        step(8);
        chk("blank_flag", 16'(blank), 16'h4);
        chk("blank_digits", digits, 16'h4FF1);
        chk("blank_code_err", 16'(code_err), 16'h2);
        chk("blank_dp", 16'(dp), 16'h0);
        chk("blank_frame_count", 16'(fcount), 16'd2);

        // Two selects low: sticky error, no capture.
        dig_in = 4'hC;
        seg_in = 8'hF9;
        step(8);
        chk("sel_err_set", 16'(sel_err), 16'h1);
        chk("sel_err_digits", digits, 16'h4FF1);

        // Reset in the middle of a valid dwell on digit 3.
        dig_in = 4'h7;
        seg_in = 8'hC0;
        step(3);
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_digits", digits, 16'hFFFF);
        chk("mid_rst_valid", 16'(digit_valid), 16'h0);
        chk("mid_rst_sel_err", 16'(sel_err), 16'h0);
        chk("mid_rst_code_err", 16'(code_err), 16'h0);
        chk("mid_rst_blank", 16'(blank), 16'h0);
        rst_n = 1'b1;
        step(4);
        chk("resettle_edge4_valid", 16'(digit_valid), 16'h0);
        step(1);
        chk("resettle_edge5_valid", 16'(digit_valid), 16'h8);
        chk("resettle_digits", digits, 16'h0FFF);
        chk("resettle_sel_err", 16'(sel_err), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
